// File: rtl/sweeper_pkg.sv
// Shared types and width helpers for the truth-table sweeper.
package sweeper_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sweep_hold_timer.sv
// Hold-window counter: counts 0..HOLD_CYC-1 and wraps, o_tc high on the last count.
module sweep_hold_timer #(
  parameter int HOLD_CYC = 10,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST_CNT) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == LAST_CNT);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector to a combinational block, samples it at the end of each hold window
// and packs the results into tt_bits. SWEEP_CHECK_EN adds expected-table comparison outputs.
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int N_IN     = 3,
  parameter int N_OUT    = 1,
  parameter int HOLD_CYC = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  output logic [N_IN-1:0]             stim,
  input  logic [N_OUT-1:0]            dut_out,
  output logic                        busy,
  output logic                        done,
  output logic [(2**N_IN)*N_OUT-1:0]  tt_bits,
  output logic [N_IN-1:0]             vec_idx
`ifdef SWEEP_CHECK_EN
  ,
  input  logic [(2**N_IN)*N_OUT-1:0]  expected_tt,
  output logic [N_IN:0]               mismatch_cnt,
  output logic                        pass
`endif
);

  localparam int NUM_VEC = 1 << N_IN;
  localparam int HOLD_W  = cnt_width(HOLD_CYC);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NUM_VEC - 1);

  state_t                         r_state;
  logic [N_IN-1:0]                r_stim;
  logic [N_IN-1:0]                r_vec_idx;
  logic                           r_busy;
  logic                           r_done;
  logic [(2**N_IN)*N_OUT-1:0]     r_tt;
  logic                           w_tc;
  logic                           w_timer_clr;
`ifdef SWEEP_CHECK_EN
  logic [N_IN:0]                  r_mism;
`endif

  // Timer only runs inside DRIVE, so it is already at zero when a sweep starts.
  assign w_timer_clr = (r_state != DRIVE) || abort;

  sweep_hold_timer #(
    .HOLD_CYC (HOLD_CYC),
    .CNT_W    (HOLD_W)
  ) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_timer_clr),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_stim    <= '0;
      r_vec_idx <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_tt      <= '0;
`ifdef SWEEP_CHECK_EN
      r_mism    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state   <= DRIVE;
            r_stim    <= '0;
            r_vec_idx <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_tt      <= '0;
`ifdef SWEEP_CHECK_EN
            r_mism    <= '0;
`endif
          end
        end
        DRIVE: begin
          if (abort) begin
            r_state   <= IDLE;
            r_stim    <= '0;
            r_vec_idx <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_tt      <= '0;
`ifdef SWEEP_CHECK_EN
            r_mism    <= '0;
`endif
          end else if (w_tc) begin
            r_tt[r_vec_idx*N_OUT +: N_OUT] <= dut_out;
`ifdef SWEEP_CHECK_EN
            if ((expected_tt[r_vec_idx*N_OUT +: N_OUT] != dut_out) && (r_mism != '1)) begin
              r_mism <= r_mism + 1'b1;
            end
`endif
            if (r_vec_idx == LAST_IDX) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_vec_idx <= r_vec_idx + 1'b1;
              r_stim    <= r_vec_idx + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stim    = r_stim;
  assign vec_idx = r_vec_idx;
  assign busy    = r_busy;
  assign done    = r_done;
  assign tt_bits = r_tt;
`ifdef SWEEP_CHECK_EN
  assign mismatch_cnt = r_mism;
  assign pass         = r_done && (r_mism == '0);
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized bench for truth_table_sweeper: a 3-input/10-cycle instance and a 2-input/1-cycle instance.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: N_IN=3, N_OUT=1, HOLD_CYC=10
  logic       a_start, a_abort, a_dout, a_busy, a_done;
  logic [2:0] a_stim, a_idx;
  logic [7:0] a_tt, a_lut;
  int         a_mode;
  // Instance B: N_IN=2, N_OUT=1, HOLD_CYC=1
  logic       b_start, b_abort, b_dout, b_busy, b_done;
  logic [1:0] b_stim, b_idx;
  logic [3:0] b_tt, b_lut;
  int         b_mode;
`ifdef SWEEP_CHECK_EN
  logic [7:0] a_exp;
  logic [3:0] a_mism;
  logic       a_pass;
  logic [3:0] b_exp;
  logic [2:0] b_mism;
  logic       b_pass;
`endif

  // Behavioural stand-ins for the block under sweep.
  function automatic logic f3(input int mode, input logic [2:0] x, input logic [7:0] lut);
    case (mode)
      0:       return (int'(x[0]) + int'(x[1]) + int'(x[2])) >= 2;
      1:       return ^x;
      default: return lut[x];
    endcase
  endfunction

  function automatic logic f2(input int mode, input logic [1:0] x, input logic [3:0] lut);
    if (mode == 0) return x[0] & x[1];
    return lut[x];
  endfunction

  assign a_dout = f3(a_mode, a_stim, a_lut);
  assign b_dout = f2(b_mode, b_stim, b_lut);

  truth_table_sweeper #(.N_IN(3), .N_OUT(1), .HOLD_CYC(10)) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .stim(a_stim),
    .dut_out(a_dout), .busy(a_busy), .done(a_done), .tt_bits(a_tt), .vec_idx(a_idx)
`ifdef SWEEP_CHECK_EN
    , .expected_tt(a_exp), .mismatch_cnt(a_mism), .pass(a_pass)
`endif
  );

  truth_table_sweeper #(.N_IN(2), .N_OUT(1), .HOLD_CYC(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .stim(b_stim),
    .dut_out(b_dout), .busy(b_busy), .done(b_done), .tt_bits(b_tt), .vec_idx(b_idx)
`ifdef SWEEP_CHECK_EN
    , .expected_tt(b_exp), .mismatch_cnt(b_mism), .pass(b_pass)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full sweep on A; optionally pulses start mid-sweep and/or asserts abort with start.
  task automatic sweep_a(input int mode, input logic [7:0] lut, input logic [7:0] exp_in,
                         input int busy_start_at, input bit abort_with_start);
    logic [7:0] ref_tt;
    int cyc;
    ref_tt = '0;
    for (int i = 0; i < 8; i++) ref_tt[i] = f3(mode, 3'(i), lut);
    @(negedge clk);
    a_mode = mode; a_lut = lut;
`ifdef SWEEP_CHECK_EN
    a_exp = exp_in;
`endif
    a_start = 1'b1; a_abort = abort_with_start;
    step();
    a_start = 1'b0; a_abort = 1'b0;
    check("a_start_busy", 32'(a_busy), 32'd1);
    check("a_start_done", 32'(a_done), 32'd0);
    check("a_start_tt", 32'(a_tt), 32'd0);
    check("a_start_stim", 32'(a_stim), 32'd0);
    cyc = 0;
    while (!a_done && cyc < 200) begin
      a_start = (cyc == busy_start_at);
      step();
      cyc++;
      if (!a_done) begin
        check("a_stim_seq", 32'(a_stim), 32'(cyc / 10));
        check("a_idx_seq", 32'(a_idx), 32'(cyc / 10));
      end
    end
    a_start = 1'b0;
    check("a_latency", 32'(cyc), 32'd80);
    check("a_end_busy", 32'(a_busy), 32'd0);
    check("a_end_tt", 32'(a_tt), 32'(ref_tt));
    check("a_end_stim", 32'(a_stim), 32'd7);
`ifdef SWEEP_CHECK_EN
    check("a_mism", 32'(a_mism), 32'($countones(ref_tt ^ exp_in)));
    check("a_pass", 32'(a_pass), 32'(ref_tt == exp_in));
`endif
  endtask

  // Start a sweep on A, wait until vector at_idx is driven plus off cycles, return with idx reached.
  task automatic run_to_idx(input int at_idx, input int off);
    int cyc;
    @(negedge clk);
    a_mode = 2; a_lut = 8'($urandom);
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    cyc = 0;
    while (a_idx != 3'(at_idx) && cyc < 200) begin
      step();
      cyc++;
    end
    repeat (off) step();
    check("a_reach_idx", 32'(a_idx), 32'(at_idx));
  endtask

  task automatic sweep_b(input int mode, input logic [3:0] lut);
    logic [3:0] ref_tt;
    int cyc;
    ref_tt = '0;
    for (int i = 0; i < 4; i++) ref_tt[i] = f2(mode, 2'(i), lut);
    @(negedge clk);
    b_mode = mode; b_lut = lut;
`ifdef SWEEP_CHECK_EN
    b_exp = ref_tt;
`endif
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    check("b_start_busy", 32'(b_busy), 32'd1);
    check("b_start_tt", 32'(b_tt), 32'd0);
    cyc = 0;
    while (!b_done && cyc < 50) begin
      if (!b_done) check("b_stim_seq", 32'(b_stim), 32'(cyc));
      step();
      cyc++;
    end
    check("b_latency", 32'(cyc), 32'd4);
    check("b_end_busy", 32'(b_busy), 32'd0);
    check("b_end_tt", 32'(b_tt), 32'(ref_tt));
`ifdef SWEEP_CHECK_EN
    check("b_pass", 32'(b_pass), 32'd1);
`endif
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_abort = 1'b0; a_mode = 0; a_lut = '0;
    b_start = 1'b0; b_abort = 1'b0; b_mode = 0; b_lut = '0;
`ifdef SWEEP_CHECK_EN
    a_exp = 8'hE8; b_exp = 4'h8;
`endif
    repeat (3) step();
    check("rst_a_stim", 32'(a_stim), 32'd0);
    check("rst_a_busy", 32'(a_busy), 32'd0);
    check("rst_a_done", 32'(a_done), 32'd0);
    check("rst_a_tt", 32'(a_tt), 32'd0);
    check("rst_a_idx", 32'(a_idx), 32'd0);
    check("rst_b_busy", 32'(b_busy), 32'd0);
    check("rst_b_tt", 32'(b_tt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Majority and XOR3, then a restart from DONE with a start pulsed while busy.
    sweep_a(0, 8'h00, 8'hE8, -1, 1'b0);
    check("a_majority", 32'(a_tt), 32'h0000_00E8);
    sweep_a(1, 8'h00, 8'hE8, -1, 1'b0);
    check("a_xor3", 32'(a_tt), 32'h0000_0096);
    sweep_a(1, 8'h00, 8'h96, 33, 1'b0);
    check("a_xor3_again", 32'(a_tt), 32'h0000_0096);

    // Abort in DONE is ignored; start+abort together in DONE restarts.
    a_abort = 1'b1;
    step();
    a_abort = 1'b0;
    check("a_done_abort_done", 32'(a_done), 32'd1);
    check("a_done_abort_tt", 32'(a_tt), 32'h0000_0096);
    sweep_a(0, 8'h00, 8'hE8, -1, 1'b1);

    // Abort at vector 4 at a random point in its window.
    run_to_idx(4, $urandom_range(0, 9));
    a_abort = 1'b1;
    step();
    a_abort = 1'b0;
    check("abort_busy", 32'(a_busy), 32'd0);
    check("abort_done", 32'(a_done), 32'd0);
    check("abort_stim", 32'(a_stim), 32'd0);
    check("abort_tt", 32'(a_tt), 32'd0);
    check("abort_idx", 32'(a_idx), 32'd0);
    repeat (3) step();
    check("abort_stays_idle", 32'(a_busy), 32'd0);
    sweep_a(0, 8'h00, 8'hE8, -1, 1'b0);

    // Reset mid-sweep at vector 5.
    run_to_idx(5, $urandom_range(0, 9));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_busy", 32'(a_busy), 32'd0);
    check("mrst_done", 32'(a_done), 32'd0);
    check("mrst_stim", 32'(a_stim), 32'd0);
    check("mrst_tt", 32'(a_tt), 32'd0);
    check("mrst_idx", 32'(a_idx), 32'd0);
    sweep_a(1, 8'h00, 8'hE8, $urandom_range(0, 78), 1'b0);

    // Single-cycle hold, AND2.
    sweep_b(0, 4'h0);
    check("b_and2", 32'(b_tt), 32'h0000_0008);

    // Random truth tables.
    for (int k = 0; k < 4; k++) begin
      sweep_a(2, 8'($urandom), 8'($urandom), int'($urandom_range(0, 100)) - 20, 1'($urandom));
    end
    for (int k = 0; k < 3; k++) begin
      sweep_b(1, 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
